// File: rtl/sin_ctrl_pkg.sv
// sin_ctrl_pkg: shared state encoding and default widths for the sine burst sequencer.
package sin_ctrl_pkg;
  localparam int DIV_W_DEF = 8;
  localparam int CNT_W_DEF = 16;
  localparam int REP_W_DEF = 8;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    FIN  = 2'd3
  } state_t;
endpackage

// File: rtl/sin_rate_div.sv
// sin_rate_div: modulo-(div+1) counter; tick flags that the count loaded at the next edge is 0,
// so the owner can register its strobe in step with the count.
module sin_rate_div
  import sin_ctrl_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] r_cnt, w_nxt;
  always_comb begin
    w_nxt = clear ? '0 : !en ? r_cnt : (r_cnt == div ? '0 : r_cnt + DIV_W'(1));
    tick  = w_nxt == '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= w_nxt;
  end
endmodule

// File: rtl/sin_burst_ctrl.sv
// sin_burst_ctrl: burst sequencer producing rate-divided gen_en strobes for the sine generator,
// N strobes on, M clocks off, repeated R times or continuously until abort.
module sin_burst_ctrl
  import sin_ctrl_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int REP_W = REP_W_DEF
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_on,
  input  logic [CNT_W-1:0] cfg_off,
  input  logic [REP_W-1:0] cfg_rep,
  output logic             gen_en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [REP_W-1:0] burst_idx
);
  state_t           r_state, w_nxt_state;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_on, r_off, r_strb, r_gap;
  logic [REP_W-1:0] r_rep, r_burst;
  logic             r_gen_en, r_busy, r_done, r_err;
  logic             w_accept, w_abort, w_last, w_burst_end, w_gap_end, w_clear, w_step, w_tick;
  // r_gen_en doubles as "a strobe is being issued this cycle" for the strobe counter
  always_comb begin
    w_accept    = r_state == IDLE && start && !abort && cfg_on != '0;
    w_abort     = r_state != IDLE && abort;
    w_last      = r_rep != '0 && r_burst == r_rep - REP_W'(1);
    w_burst_end = r_state == ON && r_gen_en && r_strb == r_on - CNT_W'(1);
    w_gap_end   = r_state == OFF && r_gap == r_off - CNT_W'(1);
    w_nxt_state = w_abort ? IDLE :
                  r_state == IDLE ? (w_accept ? ON : IDLE) :
                  r_state == ON ? (!w_burst_end ? ON : w_last ? FIN : r_off != '0 ? OFF : ON) :
                  r_state == OFF ? (w_gap_end ? ON : OFF) : IDLE;
    w_clear     = !(r_state == ON && w_nxt_state == ON && !w_burst_end);
    w_step      = w_nxt_state == ON && (w_burst_end || w_gap_end);
  end
  sin_rate_div #(.DIV_W(DIV_W)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_clear),
    .en    (r_state == ON),
    .div   (r_div),
    .tick  (w_tick)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_div    <= '0;
      r_on     <= '0;
      r_off    <= '0;
      r_rep    <= '0;
      r_strb   <= '0;
      r_gap    <= '0;
      r_burst  <= '0;
      r_gen_en <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_gen_en <= w_nxt_state == ON && w_tick;
      r_busy   <= w_nxt_state == ON || w_nxt_state == OFF;
      r_done   <= w_nxt_state == FIN;
      r_err    <= r_state == IDLE && start && !abort && cfg_on == '0;
      r_strb   <= (w_nxt_state != ON || w_burst_end) ? '0 : r_strb + CNT_W'(r_gen_en);
      r_gap    <= (r_state == OFF && w_nxt_state == OFF) ? r_gap + CNT_W'(1) : '0;
      r_burst  <= (w_accept || w_abort) ? '0 : w_step ? r_burst + REP_W'(1) : r_burst;
      if (w_accept) begin
        r_div <= cfg_div;
        r_on  <= cfg_on;
        r_off <= cfg_off;
        r_rep <= cfg_rep;
      end
    end
  end
  assign gen_en    = r_gen_en;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign burst_idx = r_burst;
endmodule

// File: tb/tb_sin_burst_ctrl.sv
// tb_sin_burst_ctrl: directed bench; expected per-cycle outputs are hand-built bit masks
// where bit c is the value required in cycle c after the start edge.
module tb_sin_burst_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  cfg_div = '0;
  logic [15:0] cfg_on = '0;
  logic [15:0] cfg_off = '0;
  logic [1:0]  cfg_rep = '0;
  logic        gen_en, busy, done, err;
  logic [1:0]  burst_idx;
  int          n_chk = 0;
  int          n_err = 0;
  int          bidx [0:31];

  always #5 clk = ~clk;

  sin_burst_ctrl #(.DIV_W(8), .CNT_W(16), .REP_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .cfg_div   (cfg_div),
    .cfg_on    (cfg_on),
    .cfg_off   (cfg_off),
    .cfg_rep   (cfg_rep),
    .gen_en    (gen_en),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .burst_idx (burst_idx)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Called at a falling edge (mid cycle 0); start is presented for the edge ending cycle 0.
  task automatic run_burst(input logic [7:0] div, input logic [15:0] on, input logic [15:0] off,
                           input logic [1:0] rep, input logic ab0, input int n,
                           input int restart_at, input int abort_at,
                           input logic [31:0] m_gen, input logic [31:0] m_busy,
                           input logic [31:0] m_done, input logic [31:0] m_err);
    cfg_div = div;
    cfg_on  = on;
    cfg_off = off;
    cfg_rep = rep;
    start   = 1'b1;
    abort   = ab0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      chk($sformatf("gen_en c%0d", c), int'(gen_en), int'(m_gen[c]));
      chk($sformatf("busy c%0d", c), int'(busy), int'(m_busy[c]));
      chk($sformatf("done c%0d", c), int'(done), int'(m_done[c]));
      chk($sformatf("err c%0d", c), int'(err), int'(m_err[c]));
      bidx[c] = int'(burst_idx);
      start = (c == restart_at);
      abort = (c == abort_at);
      if (c == restart_at) begin
        cfg_div = 8'd3;
        cfg_on  = 16'd9;
        cfg_off = 16'd5;
        cfg_rep = 2'd1;
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst gen_en", int'(gen_en), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst err", int'(err), 0);
    chk("rst burst_idx", int'(burst_idx), 0);
    rst_n = 1'b1;
    @(negedge clk);
    // two bursts of 4 with a 2-clock gap
    run_burst(8'd0, 16'd4, 16'd2, 2'd2, 1'b0, 12, 0, 0, 32'h79E, 32'h7FE, 32'h800, 32'h0);
    chk("basic bidx c6", bidx[6], 0);
    chk("basic bidx c7", bidx[7], 1);
    chk("basic bidx c11", bidx[11], 1);
    // divide by 3, single burst of 3
    run_burst(8'd2, 16'd3, 16'd0, 2'd1, 1'b0, 9, 0, 0, 32'h92, 32'hFE, 32'h100, 32'h0);
    // illegal burst length
    run_burst(8'd0, 16'd0, 16'd2, 2'd1, 1'b0, 3, 0, 0, 32'h0, 32'h0, 32'h0, 32'h2);
    // start and abort together in IDLE
    run_burst(8'd0, 16'd4, 16'd2, 2'd2, 1'b1, 4, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    // second start with other config mid-burst must not disturb the sequence
    run_burst(8'd0, 16'd4, 16'd2, 2'd2, 1'b0, 12, 3, 0, 32'h79E, 32'h7FE, 32'h800, 32'h0);
    chk("restart bidx c7", bidx[7], 1);
    // continuous mode, abort sampled at the end of cycle 15
    run_burst(8'd0, 16'd2, 16'd1, 2'd0, 1'b0, 17, 0, 15, 32'h6DB6, 32'hFFFE, 32'h0, 32'h0);
    chk("cont bidx c1", bidx[1], 0);
    chk("cont bidx c4", bidx[4], 1);
    chk("cont bidx c7", bidx[7], 2);
    chk("cont bidx c10", bidx[10], 3);
    chk("cont bidx c13", bidx[13], 0);
    // asynchronous reset in the middle of a burst
    run_burst(8'd0, 16'd4, 16'd0, 2'd1, 1'b0, 2, 0, 0, 32'h6, 32'h6, 32'h0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst gen_en", int'(gen_en), 0);
    chk("arst busy", int'(busy), 0);
    chk("arst done", int'(done), 0);
    chk("arst burst_idx", int'(burst_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_burst(8'd0, 16'd1, 16'd0, 2'd1, 1'b0, 3, 0, 0, 32'h2, 32'h2, 32'h4, 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sin_burst_ctrl.md
Name: sin_burst_ctrl

Overview:
- Sequencer that drives the `en` input of the 8-bit sine generator.
- Produces rate-divided enable strobes in bursts: N strobes on, M clocks off, repeated R times or continuously.
- Sits between the register/key front end, which supplies config and start/abort, and the sine generator.
- Output samples advance only on `gen_en` strobes.

Parameters:
- DIV_W, 8: width of the rate divider config.
- CNT_W, 16: width of the burst-length and gap-length configs and counters.
- REP_W, 8: width of the repeat count and of `burst_idx`.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- start, input, 1: level-sampled request. It is accepted only in IDLE.
- abort, input, 1: stops the sequence. It has priority over `start`.
- cfg_div, input, DIV_W: strobe period minus 1. 0 means a strobe every clock.
- cfg_on, input, CNT_W: strobes per burst. 0 is illegal.
- cfg_off, input, CNT_W: gap between bursts, in clocks. 0 means back-to-back bursts.
- cfg_rep, input, REP_W: number of bursts. 0 means continuous until abort.
- gen_en, output, 1: registered enable to the sine generator `en`.
- busy, output, 1: high from the cycle after start is accepted until done or abort.
- done, output, 1: one-cycle pulse after the final strobe of the final burst.
- err, output, 1: one-cycle pulse when start is sampled in IDLE with cfg_on == 0.
- burst_idx, output, REP_W: 0-based index of the current burst. Wraps modulo 2^REP_W in continuous mode.

Behaviour:
- Reset:
  - All outputs are 0 and all counters are 0; state is IDLE.
  - Reset takes effect asynchronously, including mid-burst.
  - After release, the block waits for a new start.
- States: IDLE, ON, OFF, FIN. All outputs are registered.
- IDLE:
  - start=1, abort=0, cfg_on!=0 at edge k: latch cfg_div/on/off/rep and go to ON. busy=1 and the first gen_en=1 appear in cycle k+1.
  - start=1 with cfg_on==0: err=1 in cycle k+1; stay in IDLE.
  - start=1 with abort=1: no action.
- ON:
  - The divider count restarts at 0 on every ON entry.
  - gen_en=1 in cycles where div_cnt==0; div_cnt counts 0..cfg_div and wraps.
  - Each strobe increments strb_cnt.
  - The cycle after the strobe with strb_cnt==cfg_on-1 (no trailing divider wait):
    - If this was the last burst (burst_idx==cfg_rep-1 and cfg_rep!=0), go to FIN.
    - Else if cfg_off!=0, go to OFF.
    - Else go to ON with burst_idx+1.
- OFF: gen_en=0 for exactly cfg_off clocks, then ON with burst_idx+1.
- FIN: done=1 and busy=0 for one cycle, then IDLE. burst_idx holds its last value until the next accepted start clears it.
- Abort:
  - Sampled in ON, OFF or FIN, it forces IDLE at the next edge.
  - gen_en=0 and busy=0 from the next cycle; no done.
  - Counters are cleared.
- Start while busy: ignored. Config changes while busy: ignored, because the latched copies are used.
- Width rules:
  - Counters are the same width as their configs; no overflow is possible for legal configs.
  - cfg_on up to 2^CNT_W-1 is supported.
  - In continuous mode, burst_idx wraps from 2^REP_W-1 to 0.

Decomposition:
- Shared package/include sin_ctrl_pkg holds:
  - the state encoding constants IDLE=2'd0, ON=2'd1, OFF=2'd2, FIN=2'd3;
  - the default widths.
- One natural sub-module: sin_rate_div, a loadable modulo-(cfg_div+1) counter with a `clear` input and a `tick` output at count 0.
- The top level holds the FSM, strb_cnt, gap counter and burst counter.

Test Plan:
- Basic bursts with gap: div=0, on=4, off=2, rep=2, start at cycle 0.
  - gen_en=1 in cycles 1-4 and 7-10, 0 in cycles 5-6.
  - burst_idx=0 in cycles 1-6, 1 in cycles 7-10.
  - done=1 in cycle 11; busy=1 in cycles 1-10.
- Divided rate: div=2, on=3, off=0, rep=1.
  - gen_en=1 only in cycles 1, 4 and 7.
  - done in cycle 8.
- Illegal length: cfg_on=0 with start.
  - err=1 in cycle 1 only; busy, gen_en and done stay 0.
- Continuous with abort: rep=0, div=0, on=2, off=1, REP_W=2, run 15 cycles.
  - burst_idx sequence is 0, 1, 2, 3, 0.
  - Abort at cycle 15 gives gen_en=0 and busy=0 from cycle 16; done is never seen.
- Asynchronous reset: rst_n low mid-ON between clock edges.
  - All outputs are 0 immediately.
  - After release, a new start (div=0, on=1, rep=1) gives gen_en in cycle 1 and done in cycle 2.
- Input collisions: start+abort together in IDLE gives no activity. A second start with different config during a burst does not change the strobe count or timing.
